// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM stream reader: SRAM pin polarities and FSM encoding.
package sram_stream_reader_pkg;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic WE_READ   = 1'b1;

    localparam int FIFO_ENTRIES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : sram_stream_reader_pkg

// File: rtl/sram_stream_fifo2.sv
// Two-entry synchronous FIFO with push/pop, full/empty/level and a flush that empties it.
module sram_stream_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       level_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == 2'd2);
    assign empty_o = (level_q == 2'd0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            level_d  = 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            level_d = level_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (do_push && !flush_i && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= data_i;
            end
        end
    end

endmodule : sram_stream_fifo2

// File: rtl/sram_stream_reader.sv
// Reads a contiguous run of SRAM words and streams them out on valid/ready at full rate.
// Optional abort input enabled by defining SRAM_STREAM_READER_ABORT_EN.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      start_addr,
    input  logic [AW:0]        len,
    output logic               busy,
    output logic               done,
    output logic               sram_cs_n,
    output logic               sram_we_n,
    output logic [WIDTH/8-1:0] sram_be_n,
    output logic [AW-1:0]      sram_addr,
    input  logic [WIDTH-1:0]   sram_rdata,
    output logic               out_valid,
`ifdef SRAM_STREAM_READER_ABORT_EN
    input  logic               abort,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready
);

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   issue_left_q, issue_left_d;
    logic [AW:0]   out_left_q, out_left_d;
    logic          rd_pend_q;
    logic          done_q, done_d;

    logic          handshake;
    logic          issue_room;
    logic          issue;
    logic          abort_hit;
    logic          fifo_full, fifo_empty;
    logic [1:0]    fifo_level;

`ifdef SRAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && (state_q == ST_RUN);
`else
    assign abort_hit = 1'b0;
`endif

    assign handshake = out_valid && out_ready;

    // Room = free entries (counting the one leaving this cycle) minus the read already in flight.
    assign issue_room = rd_pend_q ? ((fifo_level == 2'd0) || (handshake && !fifo_full))
                                  : (!fifo_full || handshake);

    assign issue = !rst && !abort_hit && (state_q == ST_RUN)
                   && (issue_left_q != '0) && issue_room;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d       = start_addr;
                        issue_left_d = len;
                        out_left_d   = len;
                        state_d      = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort_hit) begin
                    issue_left_d = '0;
                    out_left_d   = '0;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    if (issue) begin
                        addr_d       = addr_q + 1'b1;
                        issue_left_d = issue_left_q - 1'b1;
                    end
                    if (handshake) begin
                        out_left_d = out_left_q - 1'b1;
                        if (out_left_q == LEN_ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            rd_pend_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            rd_pend_q    <= issue;
            done_q       <= done_d;
        end
    end

    // Read data is only sampled in the cycle right after its select.
    sram_stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort_hit),
        .push_i  (rd_pend_q && !abort_hit),
        .data_i  (sram_rdata),
        .pop_i   (handshake && !abort_hit),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign out_last  = out_valid && (out_left_q == LEN_ONE);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign sram_cs_n = issue ? CS_ACTIVE : ~CS_ACTIVE;
    assign sram_we_n = WE_READ;
    assign sram_be_n = '1;
    assign sram_addr = addr_q;

endmodule : sram_stream_reader

// File: tb/tb_sram_stream_reader.sv
// Randomised and directed bench for sram_stream_reader against a queue-based stream model.
module tb_sram_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      len;
    logic             busy, done;
    logic             sram_cs_n, sram_we_n;
    logic [3:0]       sram_be_n;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_rdata;
    logic             out_valid, out_ready, out_last;
    logic [WIDTH-1:0] out_data;
`ifdef SRAM_STREAM_READER_ABORT_EN
    logic             abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    // Model state: expected addresses and words of the current run.
    logic [AW-1:0]    ea_q [$];
    logic [WIDTH-1:0] ed_q [$];
    logic             el_q [$];
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             prev_rst = 1'b0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               issued = 0;
    int               accepted = 0;
    int               acc_total = 0;
    int               ready_mode = 0;

    always #5 clk = ~clk;

    sram_stream_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sram_cs_n  (sram_cs_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
`ifdef SRAM_STREAM_READER_ABORT_EN
        .abort      (abort),
`endif
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    // SRAM: data valid only the cycle after a select, garbage otherwise.
    always @(posedge clk) begin
        if (!sram_cs_n) sram_rdata <= mem[sram_addr];
        else            sram_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic nb, nd, ab, hs;
        nb = m_busy;
        nd = 1'b0;
        ab = 1'b0;
`ifdef SRAM_STREAM_READER_ABORT_EN
        ab = abort && m_busy && !rst;
`endif
        if (prev_rst) begin
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_cs_n", 64'(sram_cs_n), 64'(1));
            chk("rst_addr", 64'(sram_addr), 64'(0));
            chk("rst_valid", 64'(out_valid), 64'(0));
            chk("rst_last", 64'(out_last), 64'(0));
            chk("rst_data", 64'(out_data), 64'(0));
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("we_n", 64'(sram_we_n), 64'(1));
        chk("be_n", 64'(sram_be_n), 64'(4'hF));
        if (prev_hold) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (rst) begin
            chk("rst_cycle_cs_n", 64'(sram_cs_n), 64'(1));
            ea_q.delete(); ed_q.delete(); el_q.delete();
            issued = 0; accepted = 0;
            nb = 1'b0;
        end else begin
            if (!m_busy) begin
                chk("idle_cs_n", 64'(sram_cs_n), 64'(1));
                chk("idle_valid", 64'(out_valid), 64'(0));
            end
            if (ab) begin
                chk("abort_cs_n", 64'(sram_cs_n), 64'(1));
                ea_q.delete(); ed_q.delete(); el_q.delete();
                issued = 0; accepted = 0;
                nd = 1'b1;
                nb = 1'b0;
            end else if (m_busy) begin
                if (!sram_cs_n) begin
                    if (ea_q.size() > 0) chk("rd_addr", 64'(sram_addr), 64'(ea_q.pop_front()));
                    else                 chk("stray_read", 64'(sram_cs_n), 64'(1));
                    issued++;
                end
                hs = out_valid && out_ready;
                if (hs) begin
                    acc_total++;
                    accepted++;
                    if (ed_q.size() > 0) begin
                        chk("out_data", 64'(out_data), 64'(ed_q.pop_front()));
                        if (el_q.pop_front()) begin
                            chk("out_last", 64'(out_last), 64'(1));
                            nd = 1'b1;
                            nb = 1'b0;
                        end else begin
                            chk("out_last", 64'(out_last), 64'(0));
                        end
                    end else begin
                        chk("stray_word", 64'(out_valid), 64'(0));
                    end
                end
                chk("readahead", 64'((issued - accepted) <= 2), 64'(1));
            end
            if (start && !m_busy) begin
                if (len == '0) begin
                    nd = 1'b1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        ea_q.push_back(AW'((int'(start_addr) + i) % DEPTH));
                        ed_q.push_back(mem[(int'(start_addr) + i) % DEPTH]);
                        el_q.push_back(i == int'(len) - 1);
                    end
                    nb = 1'b1;
                end
            end
        end
        prev_hold = !rst && !ab && out_valid && !out_ready;
        prev_data = out_data;
        prev_rst  = rst;
        m_done    = nd;
        m_busy    = nb;
    end

    // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin : ready_drv
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l);
        start = 1'b1;
        start_addr = a;
        len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || ed_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 64'(n < budget), 64'(1));
    endtask

    initial begin : stim
        logic [AW-1:0] seen [$];
        logic [AW-1:0] wrap_exp [4];
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[9'h010] = 32'hDEAD_0010;
        mem[9'h1FE] = 32'h1FE0_BEEF;
        mem[9'h000] = 32'h0000_F00D;
        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        len = '0;
`ifdef SRAM_STREAM_READER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic run: fixed timeline from the start cycle.
        ready_mode = 0;
        pulse_start(9'h010, 10'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t1_cs_n", 64'(sram_cs_n), 64'((k >= 1 && k <= 4) ? 0 : 1));
            if (k <= 4) chk("t1_addr", 64'(sram_addr), 64'(9'h010 + 9'(k - 1)));
            chk("t1_valid", 64'(out_valid), 64'((k >= 3 && k <= 6) ? 1 : 0));
            if (k == 3) chk("t1_data0", 64'(out_data), 64'(32'hDEAD_0010));
            if (k >= 3 && k <= 6) chk("t1_last", 64'(out_last), 64'(k == 6));
            chk("t1_done", 64'(done), 64'(k == 7));
        end
        @(posedge clk);
        #1;

        // Address wrap at the top of memory.
        wrap_exp[0] = 9'h1FE; wrap_exp[1] = 9'h1FF; wrap_exp[2] = 9'h000; wrap_exp[3] = 9'h001;
        pulse_start(9'h1FE, 10'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (!sram_cs_n) seen.push_back(sram_addr);
            if (k == 3) chk("wrap_data0", 64'(out_data), 64'(32'h1FE0_BEEF));
            if (k == 5) chk("wrap_data2", 64'(out_data), 64'(32'h0000_F00D));
        end
        chk("wrap_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("wrap_addr", 64'(seen[i]), 64'(wrap_exp[i]));
        @(posedge clk);
        #1;

        // Stalling consumer.
        ready_mode = 1;
        pulse_start(9'h080, 10'd8);
        wait_idle(200);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Zero length, then a start ignored while busy.
        pulse_start(9'h033, 10'd0);
        @(negedge clk);
        chk("len0_done", 64'(done), 64'(1));
        chk("len0_cs_n", 64'(sram_cs_n), 64'(1));
        @(posedge clk);
        #1;
        pulse_start(9'h100, 10'd5);
        pulse_start(9'h055, 10'd3);
        wait_idle(200);

        // Random runs, including back-to-back starts in the done cycle.
        for (int it = 0; it < 25; it++) begin
            ready_mode = $urandom_range(0, 2);
            pulse_start(AW'($urandom_range(0, DEPTH - 1)),
                        ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 20)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                pulse_start(AW'($urandom_range(0, DEPTH - 1)), 10'($urandom_range(1, 5)));
            end
            wait_idle(500);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Full-memory run.
        ready_mode = 0;
        pulse_start(9'h0A0, 10'(DEPTH));
        wait_idle(3000);

        // Reset in the middle of a run after two words.
        n = acc_total;
        ready_mode = 2;
        pulse_start(9'h040, 10'd6);
        for (int c = 0; c < 100 && acc_total < n + 2; c++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rst_progress", 64'(acc_total >= n + 2), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        repeat (3) @(posedge clk);
        #1;

`ifdef SRAM_STREAM_READER_ABORT_EN
        n = acc_total;
        ready_mode = 0;
        pulse_start(9'h060, 10'd6);
        for (int c = 0; c < 100 && acc_total < n + 2; c++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_done", 64'(done), 64'(1));
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk("abort_done_once", 64'(done), 64'(0));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sram_stream_reader

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
Initiator for the single-ported synchronous SRAM interface used by the on-chip RAM wrappers: active-low select, active-low write enable, active-low byte enables, and read data one cycle after select. Reads a contiguous run of words and presents them on a valid/ready stream with full throughput. Feeds display, audio and DMA paths from on-chip RAM. Never writes.

Parameters:
WIDTH, 32, data width in bits; multiple of 8.
DEPTH, 512, words in the attached RAM; power of 2, >= 128.
AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin a run; ignored while busy
start_addr  input  AW  first word address
len  input  AW+1  number of words, 0..DEPTH
busy  output  1  run in progress
done  output  1  one-cycle pulse when a run completes
sram_cs_n  output  1  SRAM select, active-low
sram_we_n  output  1  SRAM write enable, active-low; constant 1
sram_be_n  output  WIDTH/8  SRAM byte enables, active-low; constant all-ones
sram_addr  output  AW  SRAM word address
sram_rdata  input  WIDTH  SRAM read data, valid the cycle after sram_cs_n low
out_valid  output  1  stream data valid
out_ready  input  1  stream consumer ready
out_data  output  WIDTH  stream data
out_last  output  1  marks the final word of a run

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - busy=0, done=0, sram_cs_n=1, sram_addr=0.
  - out_valid=0, out_last=0, out_data=0.
  - All counters and the buffer are cleared.
- Reset asserted mid-run aborts the run the next edge. No done pulse. In-flight data is discarded.
- States: IDLE and RUN.
- IDLE, start=1 with len>0:
  - Latch the issue address from start_addr.
  - Load issue_left and out_left with len.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with len=0: no SRAM access; done=1 the following cycle; stay in IDLE.
- RUN, issue rule. sram_cs_n=0 in a cycle when both hold:
  - issue_left > 0;
  - (free buffer entries − reads in flight) > 0.
  - In that cycle sram_addr = the issue address. Afterwards the address increments modulo DEPTH (DEPTH-1 wraps to 0) and issue_left decrements.
- Capture: data is taken from sram_rdata only in the cycle after a select. The held value of sram_rdata is never relied on.
- Buffer:
  - 2-entry FIFO; out_data/out_valid are driven from its head.
  - One read is in flight at most per cycle, so with out_ready held high throughput is 1 word/cycle.
  - Latency from start to first out_valid = 3 cycles: latch, select, capture.
- Stream:
  - Once out_valid rises, it and out_data stay stable until out_valid && out_ready.
  - out_last=1 on the handshake where out_left==1.
  - out_ready=0 indefinitely stalls issue once the buffer is full; no data is lost.
- Completion: on the final handshake, go to IDLE. done=1 the next cycle; busy falls that same cycle.
- A start in the done cycle is accepted.
- sram_we_n and sram_be_n are tied inactive at all times.

Optional Feature:
SRAM_STREAM_READER_ABORT_EN
- With the macro defined, an input abort (1 bit) is added.
- abort=1 in RUN:
  - Issue stops that cycle.
  - Captured and in-flight data is discarded.
  - out_valid=0 from the next cycle.
  - The block returns to IDLE, and done pulses the next cycle.
- abort=1 in IDLE has no effect.
- Without the macro there is no abort port, and runs cannot be cut short except by rst.

Decomposition:
- Shared header: SRAM port polarity constants (CS_ACTIVE=0, WE_READ=1) and the state encoding (IDLE=0, RUN=1).
- Sub-module: sram_stream_fifo2, a 2-entry synchronous FIFO with push, pop, full, empty and level.
  - It is natural to reuse it for a future writer.

Test Plan:
- rst held 3 cycles, then released → all outputs at reset values; sram_cs_n=1 throughout.
- start_addr=0x010, len=4, out_ready=1 → sram_addr 0x010..0x013 on consecutive cycles; data on 4 consecutive cycles from cycle 3; out_last on the 4th word; done one cycle after.
- start_addr=0x1FE, len=4, DEPTH=512 → addresses 0x1FE, 0x1FF, 0x000, 0x001; data matches preloaded memory.
- len=8, out_ready toggling 1,0,0,1 repeating → all 8 words in order, none duplicated or dropped; out_data stable while stalled; at most 2 words beyond those accepted ever read ahead.
- len=0 → no sram_cs_n=0 cycle, done=1 the cycle after start. A second start while busy is ignored: no extra reads, single done.
- rst asserted mid-run after 2 of 6 words → next cycle idle, out_valid=0, no done. With SRAM_STREAM_READER_ABORT_EN, abort after word 2 → selects stop, done pulses once.
